// File: rtl/tcs_pkg.sv
// Shared constants and FSM encoding for the TCS3472 RGBC sequencer.
// Holds register indices, the command bit, ENABLE bit masks and the state enum.
package tcs_pkg;

  localparam logic [7:0] REG_ENABLE = 8'h00;
  localparam logic [7:0] REG_ATIME  = 8'h01;
  localparam logic [7:0] REG_STATUS = 8'h13;
  localparam logic [7:0] REG_CDATAL = 8'h14;
  localparam logic [7:0] CMD_BIT    = 8'h80;
  localparam logic [7:0] EN_PON     = 8'h01;
  localparam logic [7:0] EN_AEN     = 8'h02;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PON,
    S_WAIT_PON,
    S_WR_ATIME,
    S_WR_EN,
    S_RD_STATUS,
    S_WAIT_POLL,
    S_RD_DATA,
    S_PUBLISH,
    S_WAIT_PERIOD,
    S_WAIT_RETRY
  } state_t;

  function automatic logic is_wait_state(state_t s);
    return (s == S_WAIT_PON) || (s == S_WAIT_POLL) ||
           (s == S_WAIT_PERIOD) || (s == S_WAIT_RETRY);
  endfunction

  function automatic logic is_cmd_state(state_t s);
    return (s == S_WR_PON) || (s == S_WR_ATIME) || (s == S_WR_EN) ||
           (s == S_RD_STATUS) || (s == S_RD_DATA);
  endfunction

endpackage

// File: rtl/tcs_rgbc_sequencer_wait_timer.sv
// Loadable 24-bit down-counter shared by all wait states.
// Loading value N gives N+1 cycles before the zero flag is seen in the wait state.
module wait_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] load_val,
  output logic        zero
);

  logic [23:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 24'd0) begin
      count <= count - 24'd1;
    end
  end

  assign zero = (count == 24'd0);

endmodule

// File: rtl/tcs_rgbc_sequencer.sv
// Brings up a TCS3472 colour sensor through the byte-level I2C master and streams RGBC samples.
// Handshake: a request is transferred on a cycle with cmd_valid && cmd_ready; exactly one is outstanding until rsp_done.
module tcs_rgbc_sequencer
  import tcs_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR     = 7'h29,
  parameter logic [7:0]  ATIME_VAL    = 8'hF6,
  parameter logic [23:0] PON_WAIT_CYC = 24'd150000,
  parameter logic [23:0] POLL_GAP_CYC = 24'd50000,
  parameter logic [23:0] PERIOD_CYC   = 24'd500000,
  parameter logic [23:0] RETRY_CYC    = 24'd500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_rw,
  output logic [6:0]  cmd_addr,
  output logic [7:0]  cmd_reg,
  output logic [7:0]  cmd_wdata,
  input  logic        rsp_done,
  input  logic        rsp_nack,
  input  logic [7:0]  rsp_rdata,
  output logic [15:0] clear,
  output logic [15:0] red,
  output logic [15:0] green,
  output logic [15:0] blue,
  output logic        sample_valid,
  output logic        err,
  output logic        busy,
  output logic [3:0]  dbg_state
);

  state_t      state, next_state;
  logic        pending;
  logic [2:0]  idx;
  logic [7:0]  shadow [0:6];
  logic        enable_q;
  logic        done_ok, done_nack;
  logic        cmd_rw_d;
  logic [7:0]  cmd_reg_d, cmd_wdata_d;
  logic        wait_load, wait_zero;
  logic [23:0] wait_load_val;

  assign done_ok   = pending && rsp_done && !rsp_nack;
  assign done_nack = pending && rsp_done && rsp_nack;
  assign cmd_addr  = DEV_ADDR;
  assign dbg_state = state;

  wait_timer u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (wait_load),
    .load_val (wait_load_val),
    .zero     (wait_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:        if (enable)    next_state = S_WR_PON;
      S_WR_PON:      if (done_ok)   next_state = S_WAIT_PON;
      S_WAIT_PON:    if (wait_zero) next_state = S_WR_ATIME;
      S_WR_ATIME:    if (done_ok)   next_state = S_WR_EN;
      S_WR_EN:       if (done_ok)   next_state = S_RD_STATUS;
      S_RD_STATUS:   if (done_ok)   next_state = rsp_rdata[0] ? S_RD_DATA : S_WAIT_POLL;
      S_WAIT_POLL:   if (wait_zero) next_state = S_RD_STATUS;
      S_RD_DATA:     if (done_ok && idx == 3'd7) next_state = S_PUBLISH;
      S_PUBLISH:     next_state = S_WAIT_PERIOD;
      S_WAIT_PERIOD: if (wait_zero) next_state = S_RD_STATUS;
      S_WAIT_RETRY:  if (wait_zero) next_state = S_WR_PON;
      default:       next_state = S_IDLE;
    endcase
    if (done_nack) next_state = S_WAIT_RETRY;
    // Disable only takes effect where no command is in flight.
    if (!enable && (is_wait_state(state) || (pending && rsp_done))) next_state = S_IDLE;
  end

  always_comb begin
    cmd_rw_d      = 1'b0;
    cmd_reg_d     = CMD_BIT | REG_ENABLE;
    cmd_wdata_d   = 8'h00;
    wait_load_val = 24'd0;
    case (state)
      S_WR_PON:    cmd_wdata_d = EN_PON;
      S_WR_ATIME:  begin cmd_reg_d = CMD_BIT | REG_ATIME; cmd_wdata_d = ATIME_VAL; end
      S_WR_EN:     cmd_wdata_d = EN_PON | EN_AEN;
      S_RD_STATUS: begin cmd_rw_d = 1'b1; cmd_reg_d = CMD_BIT | REG_STATUS; end
      S_RD_DATA:   begin cmd_rw_d = 1'b1; cmd_reg_d = CMD_BIT | (REG_CDATAL + {5'd0, idx}); end
      default:     ;
    endcase
    case (next_state)
      S_WAIT_PON:    wait_load_val = PON_WAIT_CYC;
      S_WAIT_POLL:   wait_load_val = POLL_GAP_CYC;
      S_WAIT_PERIOD: wait_load_val = PERIOD_CYC;
      S_WAIT_RETRY:  wait_load_val = RETRY_CYC;
      default:       wait_load_val = 24'd0;
    endcase
    wait_load = (next_state != state) && is_wait_state(next_state);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid    <= 1'b0;
      pending      <= 1'b0;
      cmd_rw       <= 1'b0;
      cmd_reg      <= 8'h00;
      cmd_wdata    <= 8'h00;
      idx          <= 3'd0;
      for (int i = 0; i < 7; i++) shadow[i] <= 8'h00;
      clear        <= 16'h0;
      red          <= 16'h0;
      green        <= 16'h0;
      blue         <= 16'h0;
      sample_valid <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      enable_q     <= 1'b0;
    end else begin
      enable_q     <= enable;
      busy         <= (next_state != S_IDLE);
      sample_valid <= 1'b0;

      if (is_cmd_state(state) && !cmd_valid && !pending) begin
        cmd_valid <= 1'b1;
        cmd_rw    <= cmd_rw_d;
        cmd_reg   <= cmd_reg_d;
        cmd_wdata <= cmd_wdata_d;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
        pending   <= 1'b1;
      end else if (pending && rsp_done) begin
        pending   <= 1'b0;
      end

      if (state == S_RD_DATA) begin
        if (done_ok) begin
          if (idx != 3'd7) shadow[idx] <= rsp_rdata;
          idx <= idx + 3'd1;
        end
      end else begin
        idx <= 3'd0;
      end

      // The last byte goes straight to blue so the sample lands with the strobe.
      if (state == S_RD_DATA && next_state == S_PUBLISH) begin
        clear        <= {shadow[1], shadow[0]};
        red          <= {shadow[3], shadow[2]};
        green        <= {shadow[5], shadow[4]};
        blue         <= {rsp_rdata, shadow[6]};
        sample_valid <= 1'b1;
      end

      if (done_nack)               err <= 1'b1;
      else if (enable && !enable_q) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tcs_rgbc_sequencer.sv
// Directed bench for tcs_rgbc_sequencer with an inline I2C master responder.
// Wait parameters are shortened so gaps can be checked exactly.
module tb_tcs_rgbc_sequencer;

  localparam logic [23:0] PON    = 24'd20;
  localparam logic [23:0] POLL   = 24'd10;
  localparam logic [23:0] PERIOD = 24'd30;
  localparam logic [23:0] RETRY  = 24'd15;

  logic        clk = 1'b0;
  logic        rst, enable, cmd_ready, rsp_done, rsp_nack;
  logic [7:0]  rsp_rdata;
  logic        cmd_valid, cmd_rw, sample_valid, err, busy;
  logic [6:0]  cmd_addr;
  logic [7:0]  cmd_reg, cmd_wdata;
  logic [15:0] clear, red, green, blue;
  logic [3:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int sv_pulses = 0;
  int gap;

  logic [7:0] d1 [8] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
  logic [7:0] d2 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  tcs_rgbc_sequencer #(
    .PON_WAIT_CYC (PON),
    .POLL_GAP_CYC (POLL),
    .PERIOD_CYC   (PERIOD),
    .RETRY_CYC    (RETRY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rw       (cmd_rw),
    .cmd_addr     (cmd_addr),
    .cmd_reg      (cmd_reg),
    .cmd_wdata    (cmd_wdata),
    .rsp_done     (rsp_done),
    .rsp_nack     (rsp_nack),
    .rsp_rdata    (rsp_rdata),
    .clear        (clear),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .sample_valid (sample_valid),
    .err          (err),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sample_valid === 1'b1) sv_pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for a request, checks its fields, optionally stalls, accepts it and responds.
  task automatic serve(input string tag, input logic rw, input logic [7:0] reg_v,
                       input logic [7:0] wdata, input logic nack, input logic [7:0] rdata,
                       input int stall, output int g);
    logic [16:0] snap;
    logic        stable;
    g = 0;
    while (cmd_valid !== 1'b1 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_valid"}, cmd_valid, 1);
    check({tag, "_rw"}, cmd_rw, rw);
    check({tag, "_reg"}, cmd_reg, reg_v);
    if (!rw) check({tag, "_wdata"}, cmd_wdata, wdata);
    check({tag, "_addr"}, cmd_addr, 7'h29);
    snap   = {cmd_rw, cmd_reg, cmd_wdata};
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || {cmd_rw, cmd_reg, cmd_wdata} !== snap) stable = 1'b0;
    end
    if (stall > 0) check({tag, "_stall_stable"}, stable, 1);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check({tag, "_valid_drop"}, cmd_valid, 0);
    rsp_done  = 1'b1;
    rsp_nack  = nack;
    rsp_rdata = rdata;
    @(negedge clk);
    rsp_done  = 1'b0;
    rsp_nack  = 1'b0;
    rsp_rdata = 8'h00;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; cmd_ready = 1'b0;
    rsp_done = 1'b0; rsp_nack = 1'b0; rsp_rdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_sv", sample_valid, 0);
    check("rst_cr", {clear, red}, 0);
    check("rst_gb", {green, blue}, 0);
    check("rst_addr", cmd_addr, 7'h29);
    check("rst_reg", cmd_reg, 0);
    check("rst_state", dbg_state, 0);

    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_valid", cmd_valid, 0);

    // Bring-up, with a 20-cycle stall on the first request.
    enable = 1'b1;
    serve("pon", 0, 8'h80, 8'h01, 0, 8'h00, 20, gap);
    serve("atime", 0, 8'h81, 8'hF6, 0, 8'h00, 0, gap);
    check("pon_wait_gap", gap, PON + 2);
    serve("aen", 0, 8'h80, 8'h03, 0, 8'h00, 0, gap);
    serve("st0", 1, 8'h93, 8'h00, 0, 8'h00, 0, gap);
    check("pre_sample_out", {clear, red, green, blue} == 64'd0, 1);
    check("run_busy", busy, 1);
    serve("st1", 1, 8'h93, 8'h00, 0, 8'h00, 0, gap);
    check("poll_gap1", gap, POLL + 2);
    serve("st2", 1, 8'h93, 8'h00, 0, 8'h01, 0, gap);
    check("poll_gap2", gap, POLL + 2);
    for (int i = 0; i < 8; i++)
      serve($sformatf("d1_%0d", i), 1, 8'h94 + 8'(i), 8'h00, 0, d1[i], 0, gap);
    check("s1_pulse", sample_valid, 1);
    check("s1_clear", clear, 16'h1234);
    check("s1_red", red, 16'h5678);
    check("s1_green", green, 16'h9ABC);
    check("s1_blue", blue, 16'hDEF0);
    @(negedge clk);
    check("s1_pulse_end", sample_valid, 0);

    // Period wait, then a NACK on the third data read.
    serve("st3", 1, 8'h93, 8'h00, 0, 8'h01, 0, gap);
    check("period_gap", gap, PERIOD + 2);
    serve("n_d0", 1, 8'h94, 8'h00, 0, 8'hAA, 0, gap);
    serve("n_d1", 1, 8'h95, 8'h00, 0, 8'hBB, 0, gap);
    serve("n_d2", 1, 8'h96, 8'h00, 1, 8'hCC, 0, gap);
    check("nack_err", err, 1);
    check("nack_hold_clear", clear, 16'h1234);
    check("nack_hold_blue", blue, 16'hDEF0);
    check("nack_no_pulse", sv_pulses, 1);
    serve("retry_pon", 0, 8'h80, 8'h01, 0, 8'h00, 0, gap);
    check("retry_gap", gap, RETRY + 2);
    serve("r_atime", 0, 8'h81, 8'hF6, 0, 8'h00, 0, gap);
    serve("r_aen", 0, 8'h80, 8'h03, 0, 8'h00, 0, gap);
    serve("r_st", 1, 8'h93, 8'h00, 0, 8'h01, 0, gap);
    for (int i = 0; i < 8; i++)
      serve($sformatf("d2_%0d", i), 1, 8'h94 + 8'(i), 8'h00, 0, d2[i], 0, gap);
    check("s2_clear", clear, 16'h2211);
    check("s2_red", red, 16'h4433);
    check("s2_green", green, 16'h6655);
    check("s2_blue", blue, 16'h8877);
    check("s2_err_sticky", err, 1);
    @(negedge clk);

    // Drop enable in WAIT_PERIOD, then re-enable.
    enable = 1'b0;
    @(negedge clk);
    check("drop_busy", busy, 0);
    check("drop_state", dbg_state, 0);
    check("drop_err_kept", err, 1);
    enable = 1'b1;
    @(negedge clk);
    check("reen_err_clear", err, 0);
    check("reen_busy", busy, 1);
    serve("e_pon", 0, 8'h80, 8'h01, 0, 8'h00, 0, gap);
    serve("e_atime", 0, 8'h81, 8'hF6, 0, 8'h00, 0, gap);
    serve("e_aen", 0, 8'h80, 8'h03, 0, 8'h00, 0, gap);

    // Drop enable while a STATUS read is outstanding.
    gap = 0;
    while (cmd_valid !== 1'b1 && gap < 5000) begin
      @(negedge clk);
      gap++;
    end
    check("o_valid", cmd_valid, 1);
    check("o_reg", cmd_reg, 8'h93);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    check("o_busy_held", busy, 1);
    check("o_state_held", dbg_state, 5);
    rsp_done = 1'b1;
    rsp_rdata = 8'h01;
    @(negedge clk);
    rsp_done = 1'b0;
    rsp_rdata = 8'h00;
    check("o_idle_busy", busy, 0);
    check("o_idle_state", dbg_state, 0);
    repeat (10) @(negedge clk);
    check("o_no_cmd", cmd_valid, 0);
    check("total_pulses", sv_pulses, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
